// File: rtl/bnw_pkg.sv
// Shared widths and default geometry for the falling-block lanes.
package bnw_pkg;
    localparam int Y_W    = 10;
    localparam int BEAT_W = 7;

    localparam int Y_TOP_D  = 120;
    localparam int Y_BOT_D  = 720;
    localparam int SPEED_D  = 1;
    localparam int HIT_LO_D = 600;
    localparam int HIT_HI_D = 719;

    typedef logic [Y_W-1:0]    y_t;
    typedef logic [BEAT_W-1:0] beat_t;
endpackage

// File: rtl/lane_slots.sv
// One key lane: slot allocation, falling motion, retirement and hit select.
module lane_slots
    import bnw_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int Y_TOP  = Y_TOP_D,
    parameter int Y_BOT  = Y_BOT_D,
    parameter int SPEED  = SPEED_D,
    parameter int HIT_LO = HIT_LO_D,
    parameter int HIT_HI = HIT_HI_D
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 freeze,
    input  logic                 tick,
    input  logic                 beat_adv,
    input  logic                 spawn,
    input  logic                 hit,
    output logic [SLOTS*Y_W-1:0] y_flat,
    output logic [SLOTS-1:0]     vld,
    output logic                 hit_ok,
    output logic                 miss,
    output logic                 overflow
);
    localparam y_t YT  = y_t'(Y_TOP);
    localparam y_t YB  = y_t'(Y_BOT);
    localparam y_t SPD = y_t'(SPEED);
    localparam y_t HLO = y_t'(HIT_LO);
    localparam y_t HHI = y_t'(HIT_HI);

    y_t             y_q [SLOTS];
    y_t             y_d [SLOTS];
    logic [SLOTS-1:0] vld_d;
    logic           hit_ok_d, miss_d, ovf_d;
    logic           h_found, f_found;
    int             h_idx, f_idx;
    y_t             best, adv;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) y_d[i] = y_q[i];
        vld_d    = vld;
        hit_ok_d = 1'b0;
        miss_d   = 1'b0;
        ovf_d    = overflow;
        h_found  = 1'b0;
        h_idx    = 0;
        best     = '0;
        f_found  = 1'b0;
        f_idx    = 0;
        adv      = '0;

        // strict > keeps the lowest index on equal rows
        for (int i = 0; i < SLOTS; i++) begin
            if (vld[i] && y_q[i] >= HLO && y_q[i] <= HHI &&
                (!h_found || y_q[i] > best)) begin
                h_found = 1'b1;
                h_idx   = i;
                best    = y_q[i];
            end
        end

        for (int i = 0; i < SLOTS; i++) begin
            if (!vld[i] && !f_found) begin
                f_found = 1'b1;
                f_idx   = i;
            end
        end

        if (!freeze) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (vld[i] && tick) begin
                    adv = y_q[i] + SPD;
                    if (adv >= YB) begin
                        y_d[i]   = YB;
                        vld_d[i] = 1'b0;
                        if (!(hit && h_found && h_idx == i))
                            miss_d = 1'b1;
                    end else begin
                        y_d[i] = adv;
                    end
                end
            end

            if (hit && h_found) begin
                vld_d[h_idx] = 1'b0;
                y_d[h_idx]   = YB;
                hit_ok_d     = 1'b1;
            end

            if (beat_adv && spawn) begin
                if (f_found) begin
                    vld_d[f_idx] = 1'b1;
                    y_d[f_idx]   = YT;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < SLOTS; i++) y_q[i] <= YB;
            vld      <= '0;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < SLOTS; i++) y_q[i] <= y_d[i];
            vld      <= vld_d;
            hit_ok   <= hit_ok_d;
            miss     <= miss_d;
            overflow <= ovf_d;
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) y_flat[i*Y_W +: Y_W] = y_q[i];
    end
endmodule

// File: rtl/lane_block_gen.sv
// Falling-block generator for NUM_LANES piano-key lanes.
// Define LANE_BLOCK_HIT_EN to enable key-hit removal of blocks.
module lane_block_gen
    import bnw_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int SLOTS     = 4,
    parameter int Y_TOP     = Y_TOP_D,
    parameter int Y_BOT     = Y_BOT_D,
    parameter int SPEED     = SPEED_D,
    parameter int HIT_LO    = HIT_LO_D,
    parameter int HIT_HI    = HIT_HI_D
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           restart,
    input  logic                           stop_or_endgame,
    input  logic                           tick,
    input  logic [BEAT_W-1:0]              beat_cnt,
    input  logic [NUM_LANES-1:0]           spawn_mask,
    input  logic [NUM_LANES-1:0]           hit,
    output logic [NUM_LANES*SLOTS*Y_W-1:0] block_y,
    output logic [NUM_LANES*SLOTS-1:0]     block_vld,
    output logic [NUM_LANES-1:0]           hit_ok,
    output logic [NUM_LANES-1:0]           miss,
    output logic                           overflow
);
    logic                 clr;
    logic                 beat_adv;
    beat_t                prev_beat;
    logic [NUM_LANES-1:0] hit_en;
    logic [NUM_LANES-1:0] ovf_l;

    assign clr      = rst | restart;
    assign beat_adv = beat_cnt > prev_beat;

    always_ff @(posedge clk) begin
        if (clr) prev_beat <= '0;
        else     prev_beat <= beat_cnt;
    end

`ifdef LANE_BLOCK_HIT_EN
    assign hit_en = hit;
`else
    logic unused_hit;
    assign unused_hit = ^hit;
    assign hit_en     = '0;
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_slots #(
            .SLOTS (SLOTS),
            .Y_TOP (Y_TOP),
            .Y_BOT (Y_BOT),
            .SPEED (SPEED),
            .HIT_LO(HIT_LO),
            .HIT_HI(HIT_HI)
        ) u_lane (
            .clk     (clk),
            .clr     (clr),
            .freeze  (stop_or_endgame),
            .tick    (tick),
            .beat_adv(beat_adv),
            .spawn   (spawn_mask[l]),
            .hit     (hit_en[l]),
            .y_flat  (block_y[l*SLOTS*Y_W +: SLOTS*Y_W]),
            .vld     (block_vld[l*SLOTS +: SLOTS]),
            .hit_ok  (hit_ok[l]),
            .miss    (miss[l]),
            .overflow(ovf_l[l])
        );
    end

    assign overflow = |ovf_l;
endmodule

// File: doc/lane_block_gen.md
LANE_BLOCK_GEN -- requirements
Module: lane_block_gen

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of falling-block lanes (piano keys).
REQ-002 SHALL have parameter SLOTS, default 4: concurrent blocks per lane.
REQ-003 SHALL have parameter Y_TOP, default 120: spawn row; parameter Y_BOT, default 720: bottom/retire row.
REQ-004 SHALL have parameter SPEED, default 1: rows advanced per tick; parameters HIT_LO/HIT_HI, default 600/719: hit window.
REQ-005 SHALL have port clk, input, 1: the single clock. Reset is synchronous and active-high.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port restart, input, 1: synchronous game restart, same effect as rst.
REQ-008 SHALL have port stop_or_endgame, input, 1: freeze motion, spawns and hits.
REQ-009 SHALL have port tick, input, 1: motion strobe, one cycle wide.
REQ-010 SHALL have port beat_cnt, input, 7: current beat number.
REQ-011 SHALL have port spawn_mask, input, NUM_LANES: lanes to spawn on this beat (from the chart ROM).
REQ-012 SHALL have port hit, input, NUM_LANES: debounced key-press pulses.
REQ-013 SHALL have port block_y, output, NUM_LANES*SLOTS*10: flat row per slot, index lane*SLOTS+slot.
REQ-014 SHALL have port block_vld, output, NUM_LANES*SLOTS: slot holds a live block.
REQ-015 SHALL have ports hit_ok and miss, output, NUM_LANES each: one-cycle pulses. SHALL have port overflow, output, 1: sticky spawn-drop flag.

Function
REQ-016 SHALL detect a beat advance as beat_cnt > registered previous beat_cnt; previous value updates every cycle.
REQ-017 On beat advance with stop_or_endgame=0, each lane with spawn_mask bit set SHALL load its lowest-index free slot: vld=1, y=Y_TOP.
REQ-018 "Free" SHALL be judged from the pre-edge state; a slot retiring or hit this cycle is not reusable until the next cycle.
REQ-019 Spawn into a lane with no free slot SHALL drop the block and set overflow, which stays set until rst/restart.
REQ-020 On tick with stop_or_endgame=0, every valid slot SHALL advance y by SPEED, saturating at Y_BOT.
REQ-021 A valid slot whose advanced y is >= Y_BOT SHALL clear vld in the same edge and pulse miss for its lane for one cycle (multiple retirements in one lane produce one pulse).
REQ-022 On hit[l]=1 with stop_or_endgame=0, the valid slot of lane l with the largest y inside [HIT_LO, HIT_HI] (pre-edge value) SHALL clear vld and pulse hit_ok[l] next edge. Ties go to the lowest index. No candidate means no action.
REQ-023 A slot hit and retiring in the same cycle SHALL count as a hit only (no miss).
REQ-024 Invalid slots SHALL present y=Y_BOT.
REQ-025 Outputs SHALL be registered, with one-cycle latency from the causing input.
REQ-026 y arithmetic SHALL be 10-bit unsigned. Parameters SHALL satisfy Y_BOT+SPEED < 1024 and Y_TOP < HIT_LO <= HIT_HI < Y_BOT.

Reset
REQ-027 rst or restart at any edge, including mid-fall, SHALL clear all vld, set all y=Y_BOT, and clear previous beat, hit_ok, miss and overflow. It overrides all other events.

Configuration
REQ-028 Macro LANE_BLOCK_HIT_EN defined: hit logic per REQ-022/023 is present.
REQ-029 Macro LANE_BLOCK_HIT_EN undefined: hit is ignored, hit_ok is tied 0, and blocks leave only by retirement.

Structure
REQ-030 Package bnw_pkg SHALL hold Y_W=10, BEAT_W=7 and the default Y_TOP/Y_BOT/HIT window constants.
REQ-031 Sub-module lane_slots SHALL implement one lane (SLOTS slots, allocation, motion, hit select). The top SHALL instantiate NUM_LANES copies and OR their overflow outputs.

Verification
REQ-032 Reset then beat_cnt 3->4, spawn_mask=0001 -> slot0 of lane0 vld=1, y=120. Other slots unchanged.
REQ-033 Lane0 block at y=120, 600 ticks, SPEED=1 -> y=719 after 599 ticks. The 600th tick clears vld and pulses miss[0] once.
REQ-034 Five spawns into lane2 on beats 4,5,6,7,8 with SLOTS=4 -> four vld slots, overflow=1 after the beat-8 edge, held until restart.
REQ-035 Lane1 blocks at y=650 and y=610, hit[1] -> y=650 slot cleared, hit_ok[1] pulses. A second hit removes the 610 block. A third hit causes no action.
REQ-036 stop_or_endgame=1 with ticks, hit and a beat advance -> positions frozen, no spawn, no hit_ok/miss.
REQ-037 restart asserted mid-fall with 3 live blocks -> next edge: all vld=0, y=720, overflow=0. Also build with LANE_BLOCK_HIT_EN undefined and confirm hit_ok stays 0.
